// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with BTB prediction and IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter int          BTB_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_mispredict,
  input  logic [31:0] ex_redirect_pc,
  input  logic        ex_update_en,
  input  logic [31:0] ex_update_pc,
  input  logic [31:0] ex_update_target,
  input  logic        ex_update_taken,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_target,
  output logic        if_id_valid
);

  localparam int          IDX   = $clog2(BTB_ENTRIES);
  localparam int          TAG_W = 30 - IDX;
  localparam logic [31:0] NOP   = 32'h00000013;

  // Bit 1 of the counter is the predicted direction.
  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    STRONG_TAKEN     = 2'b10,
    WEAK_TAKEN       = 2'b11
  } ctr_t;

  logic [31:0]      pc;
  logic [31:0]      next_pc;
  logic             btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]      btb_target [BTB_ENTRIES];
  ctr_t             btb_state  [BTB_ENTRIES];

  logic [IDX-1:0]   look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;

  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             unused_bits;

  assign imem_addr   = pc;
  assign look_idx    = pc[IDX+1:2];
  assign look_tag    = pc[31:IDX+2];
  assign look_hit    = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
  assign pred_taken  = look_hit && btb_state[look_idx][1];
  assign pred_target = pred_taken ? btb_target[look_idx] : 32'd0;

  assign upd_idx     = ex_update_pc[IDX+1:2];
  assign upd_tag     = ex_update_pc[31:IDX+2];
  assign upd_hit     = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
  assign unused_bits = ^ex_update_pc[1:0];

  function automatic ctr_t train(input ctr_t s, input logic taken);
    ctr_t n;
    n = s;
    if (taken) begin
      case (s)
        STRONG_NOT_TAKEN: n = WEAK_NOT_TAKEN;
        WEAK_NOT_TAKEN:   n = WEAK_TAKEN;
        WEAK_TAKEN:       n = STRONG_TAKEN;
        STRONG_TAKEN:     n = STRONG_TAKEN;
      endcase
    end else begin
      case (s)
        STRONG_TAKEN:     n = WEAK_TAKEN;
        WEAK_TAKEN:       n = WEAK_NOT_TAKEN;
        WEAK_NOT_TAKEN:   n = STRONG_NOT_TAKEN;
        STRONG_NOT_TAKEN: n = STRONG_NOT_TAKEN;
      endcase
    end
    return n;
  endfunction

  always_comb begin
    next_pc = pc + 32'd4;
    if (ex_mispredict)   next_pc = ex_redirect_pc;
    else if (stall)      next_pc = pc;
    else if (pred_taken) next_pc = pred_target;
  end

  // A mispredict squashes IF/ID even while the hazard unit is stalling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc                <= RESET_PC;
      if_id_instruction <= NOP;
      if_id_pc          <= 32'd0;
      if_id_pred_taken  <= 1'b0;
      if_id_pred_target <= 32'd0;
      if_id_valid       <= 1'b0;
    end else begin
      pc <= next_pc;
      if (ex_mispredict) begin
        if_id_instruction <= NOP;
        if_id_pc          <= 32'd0;
        if_id_pred_taken  <= 1'b0;
        if_id_pred_target <= 32'd0;
        if_id_valid       <= 1'b0;
      end else if (!stall) begin
        if_id_instruction <= imem_rdata;
        if_id_pc          <= pc;
        if_id_pred_taken  <= pred_taken;
        if_id_pred_target <= pred_target;
        if_id_valid       <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= 32'd0;
        btb_state[i]  <= STRONG_NOT_TAKEN;
      end
    end else if (ex_update_en) begin
      if (upd_hit) begin
        btb_state[upd_idx] <= train(btb_state[upd_idx], ex_update_taken);
        if (ex_update_taken) btb_target[upd_idx] <= ex_update_target;
      end else if (ex_update_taken) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= ex_update_target;
        btb_state[upd_idx]  <= WEAK_TAKEN;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam int          N   = 8;
  localparam int          IDX = $clog2(N);
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        ex_mispredict = 1'b0;
  logic [31:0] ex_redirect_pc = 32'd0;
  logic        ex_update_en = 1'b0;
  logic [31:0] ex_update_pc = 32'd0;
  logic [31:0] ex_update_target = 32'd0;
  logic        ex_update_taken = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;
  logic        if_id_pred_taken;
  logic [31:0] if_id_pred_target;
  logic        if_id_valid;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BAD0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage #(.RESET_PC(32'h00000000), .BTB_ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_mispredict(ex_mispredict), .ex_redirect_pc(ex_redirect_pc),
    .ex_update_en(ex_update_en), .ex_update_pc(ex_update_pc),
    .ex_update_target(ex_update_target), .ex_update_taken(ex_update_taken),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
    .if_id_pred_taken(if_id_pred_taken), .if_id_pred_target(if_id_pred_target),
    .if_id_valid(if_id_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: confidence 0..3 (0/1 not taken, 2/3 taken), BTB as plain arrays.
  logic [31:0] m_pc, m_instr, m_ifpc, m_ptgt;
  logic        m_ptk, m_valid;
  bit          m_bv   [N];
  logic [31:0] m_btag [N];
  logic [31:0] m_btgt [N];
  int          m_conf [N];

  int          li, ui;
  logic        l_tk, u_hit;
  logic [31:0] l_tgt, m_next;

  always_comb begin
    li     = int'((m_pc >> 2) % N);
    l_tk   = m_bv[li] && (m_btag[li] == (m_pc >> (IDX + 2))) && (m_conf[li] >= 2);
    l_tgt  = l_tk ? m_btgt[li] : 32'd0;
    ui     = int'((ex_update_pc >> 2) % N);
    u_hit  = m_bv[ui] && (m_btag[ui] == (ex_update_pc >> (IDX + 2)));
    if (ex_mispredict) m_next = ex_redirect_pc;
    else if (stall)    m_next = m_pc;
    else if (l_tk)     m_next = l_tgt;
    else               m_next = m_pc + 32'd4;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 32'd0;
      m_instr <= NOP;
      m_ifpc  <= 32'd0;
      m_ptk   <= 1'b0;
      m_ptgt  <= 32'd0;
      m_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        m_bv[i]   <= 1'b0;
        m_conf[i] <= 0;
      end
    end else begin
      m_pc <= m_next;
      if (ex_mispredict) begin
        m_instr <= NOP; m_ifpc <= 32'd0; m_ptk <= 1'b0; m_ptgt <= 32'd0; m_valid <= 1'b0;
      end else if (!stall) begin
        m_instr <= mem_word(m_pc); m_ifpc <= m_pc; m_ptk <= l_tk; m_ptgt <= l_tgt; m_valid <= 1'b1;
      end
      if (ex_update_en) begin
        if (u_hit) begin
          if (ex_update_taken) begin
            m_conf[ui] <= (m_conf[ui] >= 3) ? 3 : m_conf[ui] + 1;
            m_btgt[ui] <= ex_update_target;
          end else begin
            m_conf[ui] <= (m_conf[ui] <= 0) ? 0 : m_conf[ui] - 1;
          end
        end else if (ex_update_taken) begin
          m_bv[ui]   <= 1'b1;
          m_btag[ui] <= ex_update_pc >> (IDX + 2);
          m_btgt[ui] <= ex_update_target;
          m_conf[ui] <= 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model imem_addr", imem_addr, m_pc);
    chk("model if_id_instruction", if_id_instruction, m_instr);
    chk("model if_id_pc", if_id_pc, m_ifpc);
    chk("model if_id_pred_taken", {31'd0, if_id_pred_taken}, {31'd0, m_ptk});
    chk("model if_id_pred_target", if_id_pred_target, m_ptgt);
    chk("model if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
  end

  task automatic step(input logic s, input logic mis, input logic [31:0] rpc,
                      input logic ue, input logic [31:0] upc, input logic [31:0] ut,
                      input logic tk);
    stall = s; ex_mispredict = mis; ex_redirect_pc = rpc;
    ex_update_en = ue; ex_update_pc = upc; ex_update_target = ut; ex_update_taken = tk;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic redirect(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic train(input logic [31:0] a, input logic [31:0] t, input logic tk);
    step(1'b0, 1'b0, 32'd0, 1'b1, a, t, tk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset imem_addr", imem_addr, 32'd0);
    chk("reset instruction", if_id_instruction, NOP);
    chk("reset valid", {31'd0, if_id_valid}, 32'd0);
    rst = 1'b0;

    idle();
    chk("seq imem_addr 4", imem_addr, 32'h4);
    chk("seq if_id_pc 0", if_id_pc, 32'h0);
    chk("seq instruction word0", if_id_instruction, mem_word(32'h0));
    chk("seq valid", {31'd0, if_id_valid}, 32'd1);
    idle();
    chk("seq imem_addr 8", imem_addr, 32'h8);
    idle();
    idle();
    chk("pre-stall imem_addr", imem_addr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("stall imem_addr", imem_addr, 32'h10);
      chk("stall if_id_pc", if_id_pc, 32'hC);
    end
    idle();
    chk("resume if_id_pc", if_id_pc, 32'h10);
    idle();
    chk("resume if_id_pc 14", if_id_pc, 32'h14);

    step(1'b1, 1'b1, 32'h200, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("mispredict imem_addr", imem_addr, 32'h200);
    chk("mispredict nop", if_id_instruction, NOP);
    chk("mispredict valid", {31'd0, if_id_valid}, 32'd0);
    idle();
    chk("redirect if_id_pc", if_id_pc, 32'h200);

    step(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1);
    idle();
    chk("alloc pred_taken", {31'd0, if_id_pred_taken}, 32'd1);
    chk("alloc pred_target", if_id_pred_target, 32'h100);
    chk("alloc imem_addr", imem_addr, 32'h100);

    train(32'h40, 32'h0, 1'b0);
    train(32'h40, 32'h0, 1'b0);
    redirect(32'h40);
    idle();
    chk("wnt pred_taken", {31'd0, if_id_pred_taken}, 32'd0);
    chk("wnt imem_addr", imem_addr, 32'h44);
    train(32'h40, 32'h0, 1'b0);
    train(32'h40, 32'h0, 1'b0);
    train(32'h40, 32'h100, 1'b1);
    redirect(32'h40);
    idle();
    chk("snt->wnt pred_taken", {31'd0, if_id_pred_taken}, 32'd0);
    chk("snt->wnt imem_addr", imem_addr, 32'h44);

    train(32'h40, 32'h100, 1'b1);
    redirect(32'h40);
    idle();
    chk("wt imem_addr", imem_addr, 32'h100);
    train(32'h60, 32'h300, 1'b1);
    redirect(32'h40);
    idle();
    chk("alias pred_taken", {31'd0, if_id_pred_taken}, 32'd0);
    chk("alias imem_addr", imem_addr, 32'h44);
    redirect(32'h60);
    train(32'h60, 32'h0, 1'b0);
    chk("same-cycle old prediction", imem_addr, 32'h300);
    chk("same-cycle pred_taken", {31'd0, if_id_pred_taken}, 32'd1);
    redirect(32'h60);
    idle();
    chk("after update pred_taken", {31'd0, if_id_pred_taken}, 32'd0);
    chk("after update imem_addr", imem_addr, 32'h64);

    redirect(32'hFFFFFFFC);
    idle();
    chk("wrap imem_addr", imem_addr, 32'h0);
    chk("wrap if_id_pc", if_id_pc, 32'hFFFFFFFC);

    #1 rst = 1'b1;
    #1;
    chk("async reset imem_addr", imem_addr, 32'd0);
    chk("async reset valid", {31'd0, if_id_valid}, 32'd0);
    chk("async reset instruction", if_id_instruction, NOP);
    @(posedge clk);
    #2 rst = 1'b0;

    repeat (3000) begin
      logic [31:0] rpc, upc, utg;
      rpc = ($urandom_range(0, 99) == 0) ? 32'hFFFFFFFC : 32'($urandom_range(0, 63)) << 2;
      upc = 32'($urandom_range(0, 63)) << 2;
      utg = 32'($urandom_range(0, 63)) << 2;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rpc,
           $urandom_range(0, 9) < 3, upc, utg, 1'($urandom_range(0, 1)));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
